// File: rtl/axis_stream2lite_rx_if.sv
// Stream handshake bundle between the multiplier datapath (master) and the
// lite receive block (slave).
interface axis_stream2lite_rx_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_stream2lite_rx.sv
// Captures one stream packet of up to MAX_WORDS words and holds it, with
// word count and truncation status, until software acknowledges it.
module axis_stream2lite_rx #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int MAX_WORDS            = 4
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESET,
  axis_stream2lite_rx_if.slave            s_axis,
  input  logic                            en,
  input  logic                            ack,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] data0,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] data1,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] data2,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] data3,
  output logic [2:0]                      word,
  output logic                            done,
  output logic                            trunc,
  output logic                            done_pulse,
  output logic                            busy
);
  localparam logic [1:0] LAST_IDX = 2'(MAX_WORDS - 1);

  typedef enum logic [1:0] {RECV, DRAIN, HOLD} state_t;

  state_t st, nxt;
  logic [1:0] idx;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] regs [MAX_WORDS];
  logic ready, fire;

  // Ready never looks at tvalid; once a packet is underway en no longer gates it.
  assign ready = !S_AXIS_ARESET &&
                 ((st == DRAIN) || ((st == RECV) && (en || (idx != 2'd0))));
  assign fire  = s_axis.tvalid && ready;
  assign s_axis.tready = ready;
  assign busy  = ((st == RECV) && (idx != 2'd0)) || (st == DRAIN);

  assign data0 = regs[0];
  assign data1 = regs[1];
  assign data2 = regs[2];
  assign data3 = regs[3];

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) st <= RECV;
    else               st <= nxt;
  end

  always_comb begin
    nxt = st;
    case (st)
      RECV: begin
        if (fire) begin
          if (s_axis.tlast)          nxt = HOLD;
          else if (idx == LAST_IDX)  nxt = DRAIN;
        end
      end
      DRAIN:   if (fire && s_axis.tlast) nxt = HOLD;
      HOLD:    if (ack)                  nxt = RECV;
      default:                           nxt = RECV;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      idx        <= 2'd0;
      regs       <= '{default: '0};
      word       <= 3'd0;
      done       <= 1'b0;
      trunc      <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (st)
        RECV: begin
          if (fire) begin
            regs[idx] <= s_axis.tdata;
            word      <= {1'b0, idx} + 3'd1;
            idx       <= idx + 2'd1;
            if (idx == 2'd0) trunc <= 1'b0;
            if (s_axis.tlast) begin
              done       <= 1'b1;
              done_pulse <= 1'b1;
              trunc      <= 1'b0;
              idx        <= 2'd0;
            end else if (idx == LAST_IDX) begin
              trunc <= 1'b1;
              idx   <= 2'd0;
            end
          end
        end
        // Overflow beats are swallowed; word already reads MAX_WORDS.
        DRAIN: begin
          if (fire && s_axis.tlast) begin
            done       <= 1'b1;
            done_pulse <= 1'b1;
          end
        end
        HOLD: begin
          if (ack) begin
            done <= 1'b0;
            idx  <= 2'd0;
          end
        end
        default: idx <= 2'd0;
      endcase
    end
  end
endmodule
